// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, limits and helpers for mem_read_arbiter.
// Also supplies default widths for the `ADDR_WIDTH / `DATA_WIDTH macros
// when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

    // Upper bound on the number of refill engines sharing the port.
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_e;

    // ARLEN carries the beat count directly; zero still moves one beat.
    function automatic int unsigned burst_beats(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one requester per grant. Round-robin from a rotating
// pointer by default; with MEM_ARB_FIXED_PRIO_EN defined the lowest index
// always wins and no pointer exists.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               any_req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner
);

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;

    // Pointer moves just past the requester that was granted; explicit wrap
    // keeps non-power-of-two requester counts in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    logic unused_rr_inputs;
    assign unused_rr_inputs = ^{clk, rst_n, advance};
`endif

    // Scan requesters starting from the priority origin; first active one wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
`else
            idx = IDX_W'(i);
`endif
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    assign grant = any_req ? (NUM_REQ'(1) << winner) : '0;

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI AR/R channel pair between NUM_REQ cache
// refill engines, one burst at a time. Grant is held until the last beat.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// instead of round-robin.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   req_arid,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [NUM_REQ-1:0]            req_rvalid,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_rlast,
    output logic                          mem_arvalid,
    output logic [ADDR_WIDTH-1:0]         mem_araddr,
    output logic [LEN_WIDTH-1:0]          mem_arlen,
    output logic [ID_WIDTH-1:0]           mem_arid,
    input  logic                          mem_arready,
    input  logic                          mem_rvalid,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          mem_rready,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("mem_read_arbiter: NUM_REQ out of range");
    end

    arb_state_e           state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     winner;
    logic [NUM_REQ-1:0]   grant;
    logic                 any_req;
    logic                 grant_take;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 ar_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [ID_WIDTH-1:0]  id_q;

    assign grant_take = (state == IDLE) && any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_arvalid),
        .advance (grant_take),
        .any_req (any_req),
        .grant   (grant),
        .winner  (winner)
    );

    // Burst FSM: capture the winner's request, present it downstream, count beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the captured AR fields are reset too so the memory side never sees X after reset.
            state      <= IDLE;
            owner      <= '0;
            beat_cnt   <= '0;
            ar_valid_q <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_take) begin
                        owner      <= winner;
                        addr_q     <= req_araddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        len_q      <= req_arlen[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
                        id_q       <= req_arid[int'(winner)*ID_WIDTH +: ID_WIDTH];
                        ar_valid_q <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_arready) begin
                        ar_valid_q <= 1'b0;
                        beat_cnt   <= LEN_WIDTH'(burst_beats(32'(len_q)));
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == LEN_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Requester-side handshakes: accept pulse in IDLE, R beats steered to the owner.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        req_rlast   = 1'b0;
        if (state == IDLE && rst_n) begin
            req_arready = grant;
        end
        if (state == DATA && mem_rvalid) begin
            req_rvalid[owner] = 1'b1;
            req_rlast         = (beat_cnt == LEN_WIDTH'(1));
        end
    end

    assign req_rdata   = mem_rdata;
    assign mem_arvalid = ar_valid_q;
    assign mem_araddr  = addr_q;
    assign mem_arlen   = len_q;
    assign mem_arid    = id_q;
    assign mem_rready  = 1'b1;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: table-driven and randomized checks of mem_read_arbiter.
module tb_mem_read_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int LEN_WIDTH  = 4;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_arvalid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen;
    logic [NUM_REQ*ID_WIDTH-1:0]   req_arid;
    logic [NUM_REQ-1:0]            req_arready;
    logic [NUM_REQ-1:0]            req_rvalid;
    logic [DATA_WIDTH-1:0]         req_rdata;
    logic                          req_rlast;
    logic                          mem_arvalid;
    logic [ADDR_WIDTH-1:0]         mem_araddr;
    logic [LEN_WIDTH-1:0]          mem_arlen;
    logic [ID_WIDTH-1:0]           mem_arid;
    logic                          mem_arready;
    logic                          mem_rvalid;
    logic [DATA_WIDTH-1:0]         mem_rdata;
    logic                          mem_rready;
    logic                          busy;

    mem_read_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_arvalid (req_arvalid),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arid    (req_arid),
        .req_arready (req_arready),
        .req_rvalid  (req_rvalid),
        .req_rdata   (req_rdata),
        .req_rlast   (req_rlast),
        .mem_arvalid (mem_arvalid),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arid    (mem_arid),
        .mem_arready (mem_arready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rready  (mem_rready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled mid-cycle, well clear of posedge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [3:0] l, input logic [3:0] id);
        req_araddr[r*ADDR_WIDTH +: ADDR_WIDTH] = a;
        req_arlen[r*LEN_WIDTH +: LEN_WIDTH]    = l;
        req_arid[r*ID_WIDTH +: ID_WIDTH]       = id;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_arvalid = '0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Present a request vector in IDLE and expect a one-cycle accept to exp_w.
    task automatic do_grant(input logic [NUM_REQ-1:0] mask, input int exp_w, input string tag);
        req_arvalid = mask;
        settle();
        check({tag, " arready"}, req_arready, 64'(1) << exp_w);
        check({tag, " idle busy"}, busy, 0);
        tick();
        req_arvalid = '0;
    endtask

    // Drive the downstream side of one burst and check everything the owner sees.
    task automatic serve(input int owner, input int beats, input logic [31:0] addr,
                         input logic [3:0] len, input logic [3:0] id,
                         input int ar_delay, input bit gaps, input string tag);
        int  seen;
        int  budget;
        bit  v;
        logic [31:0] d;
        mem_arready = 1'b0;
        for (int c = 0; c < ar_delay; c++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            settle();
            check({tag, " wait arvalid"}, mem_arvalid, 1);
            check({tag, " wait araddr"}, mem_araddr, addr);
            check({tag, " wait arlen"}, mem_arlen, len);
            check({tag, " wait arid"}, mem_arid, id);
            check({tag, " wait rvalid"}, req_rvalid, 0);
            tick();
        end
        mem_rvalid  = 1'b0;
        mem_arready = 1'b1;
        settle();
        check({tag, " arvalid"}, mem_arvalid, 1);
        check({tag, " araddr"}, mem_araddr, addr);
        check({tag, " arlen"}, mem_arlen, len);
        check({tag, " arid"}, mem_arid, id);
        tick();
        mem_arready = 1'b0;
        seen   = 0;
        budget = 0;
        while (seen < beats && budget < 200) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = $urandom;
            mem_rvalid = v;
            mem_rdata  = d;
            settle();
            check({tag, " rvalid"}, req_rvalid, v ? (64'(1) << owner) : 64'(0));
            check({tag, " rlast"}, req_rlast, (v && seen == beats - 1) ? 1 : 0);
            check({tag, " data busy"}, busy, 1);
            if (v) check({tag, " rdata"}, req_rdata, d);
            tick();
            if (v) seen++;
            budget++;
        end
        if (seen < beats) check({tag, " beat timeout"}, seen, beats);
        mem_rvalid = 1'b0;
        settle();
        check({tag, " end busy"}, busy, 0);
        check({tag, " end arvalid"}, mem_arvalid, 0);
    endtask

    typedef struct {
        logic [1:0]  arvalid;
        logic        m_arready;
        logic        m_rvalid;
        logic [31:0] rdata;
        logic [1:0]  e_arready;
        logic        e_arvalid;
        logic [1:0]  e_rvalid;
        logic        e_rlast;
        logic        e_busy;
        logic [31:0] e_addr;
        logic [3:0]  e_len;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int            model_ptr;
        int            w;
        int            ln;
        logic [1:0]    mask;
        logic [31:0]   r_addr [NUM_REQ];
        logic [3:0]    r_len  [NUM_REQ];
        logic [3:0]    r_id   [NUM_REQ];

        // Single request from requester 1: 0x1000, 4 beats, a gap, then a stray beat in IDLE.
        vecs[0]  = '{2'b10, 0, 0, 32'h0,    2'b10, 0, 2'b00, 0, 0, 32'h0,    4'd0};
        vecs[1]  = '{2'b00, 0, 0, 32'h0,    2'b00, 1, 2'b00, 0, 1, 32'h1000, 4'd4};
        vecs[2]  = '{2'b00, 1, 0, 32'h0,    2'b00, 1, 2'b00, 0, 1, 32'h1000, 4'd4};
        vecs[3]  = '{2'b00, 0, 1, 32'hA1,   2'b00, 0, 2'b10, 0, 1, 32'h1000, 4'd4};
        vecs[4]  = '{2'b00, 0, 1, 32'hA2,   2'b00, 0, 2'b10, 0, 1, 32'h1000, 4'd4};
        vecs[5]  = '{2'b00, 0, 0, 32'h0,    2'b00, 0, 2'b00, 0, 1, 32'h1000, 4'd4};
        vecs[6]  = '{2'b00, 0, 1, 32'hA3,   2'b00, 0, 2'b10, 0, 1, 32'h1000, 4'd4};
        vecs[7]  = '{2'b00, 0, 1, 32'hA4,   2'b00, 0, 2'b10, 1, 1, 32'h1000, 4'd4};
        vecs[8]  = '{2'b00, 0, 0, 32'h0,    2'b00, 0, 2'b00, 0, 0, 32'h1000, 4'd4};
        vecs[9]  = '{2'b00, 0, 1, 32'hBAD,  2'b00, 0, 2'b00, 0, 0, 32'h1000, 4'd4};
        vecs[10] = '{2'b00, 0, 0, 32'h0,    2'b00, 0, 2'b00, 0, 0, 32'h1000, 4'd4};

        rst_n       = 1'b0;
        req_arvalid = 2'b11;
        req_araddr  = '0;
        req_arlen   = '0;
        req_arid    = '0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        #3;
        check("reset mem_rready", mem_rready, 1);
        check("reset mem_arvalid", mem_arvalid, 0);
        check("reset req_arready", req_arready, 0);
        check("reset req_rvalid", req_rvalid, 0);
        check("reset req_rlast", req_rlast, 0);
        check("reset busy", busy, 0);
        check("reset mem_araddr", mem_araddr, 0);
        check("reset mem_arlen", mem_arlen, 0);
        check("reset mem_arid", mem_arid, 0);
        req_arvalid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        set_req(1, 32'h1000, 4'd4, 4'd3);
        for (int i = 0; i < 11; i++) begin
            req_arvalid = vecs[i].arvalid;
            mem_arready = vecs[i].m_arready;
            mem_rvalid  = vecs[i].m_rvalid;
            mem_rdata   = vecs[i].rdata;
            settle();
            check($sformatf("vec%0d arready", i), req_arready, vecs[i].e_arready);
            check($sformatf("vec%0d arvalid", i), mem_arvalid, vecs[i].e_arvalid);
            check($sformatf("vec%0d rvalid", i), req_rvalid, vecs[i].e_rvalid);
            check($sformatf("vec%0d rlast", i), req_rlast, vecs[i].e_rlast);
            check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d araddr", i), mem_araddr, vecs[i].e_addr);
            check($sformatf("vec%0d arlen", i), mem_arlen, vecs[i].e_len);
            if (vecs[i].e_rvalid != 0) check($sformatf("vec%0d rdata", i), req_rdata, vecs[i].rdata);
            tick();
        end
        mem_rvalid = 1'b0;

        // Simultaneous requests from reset: 0, then 1 (or 0 again with fixed priority), then 0.
        do_reset();
        set_req(0, 32'h2000, 4'd2, 4'd1);
        set_req(1, 32'h3000, 4'd1, 4'd2);
        do_grant(2'b11, 0, "sim1");
        serve(0, 2, 32'h2000, 4'd2, 4'd1, 0, 0, "sim1");
        w = FIXED_PRIO ? 0 : 1;
        do_grant(2'b11, w, "sim2");
        if (w == 0) serve(0, 2, 32'h2000, 4'd2, 4'd1, 0, 0, "sim2");
        else        serve(1, 1, 32'h3000, 4'd1, 4'd2, 0, 0, "sim2");
        do_grant(2'b11, 0, "sim3");
        serve(0, 2, 32'h2000, 4'd2, 4'd1, 0, 0, "sim3");

        // Downstream backpressure for 5 cycles with stray R beats during ADDR.
        set_req(0, 32'hABCD0, 4'd3, 4'd5);
        do_grant(2'b01, 0, "bp");
        serve(0, 3, 32'hABCD0, 4'd3, 4'd5, 5, 0, "bp");

        // ARLEN of zero still returns exactly one beat.
        set_req(1, 32'h4440, 4'd0, 4'd7);
        do_grant(2'b10, 1, "len0");
        serve(1, 1, 32'h4440, 4'd0, 4'd7, 0, 0, "len0");

        // Reset asserted after 2 of 4 beats; outputs clear at once, then normal service.
        do_reset();
        set_req(1, 32'h5000, 4'd4, 4'd9);
        do_grant(2'b10, 1, "rst");
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        tick();
        tick();
        settle();
        check("rst pre rvalid", req_rvalid, 2'b10);
        rst_n = 1'b0;
        #1;
        check("rst async rvalid", req_rvalid, 0);
        check("rst async rlast", req_rlast, 0);
        check("rst async busy", busy, 0);
        check("rst async arvalid", mem_arvalid, 0);
        check("rst async araddr", mem_araddr, 0);
        check("rst async rready", mem_rready, 1);
        mem_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 32'h6000, 4'd2, 4'd4);
        do_grant(2'b11, 0, "post");
        serve(0, 2, 32'h6000, 4'd2, 4'd4, 1, 0, "post");

        // Randomized bursts against a transaction-level model of arbitration.
        do_reset();
        model_ptr = 0;
        for (int t = 0; t < 40; t++) begin
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < NUM_REQ; r++) begin
                r_addr[r] = $urandom;
                r_len[r]  = 4'($urandom_range(0, 6));
                r_id[r]   = 4'($urandom);
                set_req(r, r_addr[r], r_len[r], r_id[r]);
            end
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = FIXED_PRIO ? k : (model_ptr + k) % NUM_REQ;
                if (w < 0 && mask[c]) w = c;
            end
            model_ptr = (w + 1) % NUM_REQ;
            ln = (r_len[w] == 0) ? 1 : int'(r_len[w]);
            do_grant(mask, w, $sformatf("rnd%0d", t));
            serve(w, ln, r_addr[w], r_len[w], r_id[w], $urandom_range(0, 3), 1'b1,
                  $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single AXI read-address/read-data channel pair between NUM_REQ cache refill engines (I-cache = requester 0, D-cache = requester 1 by default).
- Grants one burst at a time, round-robin, and holds the grant until the whole burst has returned.
- Each requester sees a private AR/R handshake. The memory side sees one well-formed AXI read master.
- Sits between the cache refill state machines and the memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, `ADDR_WIDTH, byte address width.
- DATA_WIDTH, `DATA_WIDTH, read data width.
- ID_WIDTH, 4, ARID width.
- LEN_WIDTH, 4, ARLEN width. ARLEN is the beat count (codebase convention). ARLEN==0 is treated as 1 beat.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_arvalid  in  NUM_REQ  per-requester read request
- req_araddr  in  NUM_REQ*ADDR_WIDTH  packed request addresses
- req_arlen  in  NUM_REQ*LEN_WIDTH  packed beat counts
- req_arid  in  NUM_REQ*ID_WIDTH  packed IDs
- req_arready  out  NUM_REQ  one-hot accept pulse
- req_rvalid  out  NUM_REQ  one-hot data-beat valid to the owner
- req_rdata  out  DATA_WIDTH  broadcast read data
- req_rlast  out  1  last beat of the current burst
- mem_arvalid  out  1  downstream AR valid
- mem_araddr  out  ADDR_WIDTH  downstream address
- mem_arlen  out  LEN_WIDTH  downstream beat count
- mem_arid  out  ID_WIDTH  downstream ID
- mem_arready  in  1  downstream AR ready
- mem_rvalid  in  1  downstream R valid
- mem_rdata  in  DATA_WIDTH  downstream R data
- mem_rready  out  1  downstream R ready; always 1 (caches always consume)
- busy  out  1  a burst is in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n low): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0. All valid/ready outputs are 0 except mem_rready=1. mem_araddr, mem_arlen and mem_arid are 0.
- States:
  - IDLE: if any req_arvalid, pick the winner starting from rr_ptr. Pulse req_arready[winner] combinationally in the same cycle. Capture addr/len/id into registers; owner<=winner; rr_ptr<=winner+1 (mod NUM_REQ); go to ADDR.
  - ADDR: mem_arvalid=1 with the registered fields, held stable until mem_arready. On mem_arready, beat_cnt<=max(len,1) and go to DATA.
  - DATA: req_rvalid[owner]=mem_rvalid; req_rdata=mem_rdata. Each mem_rvalid decrements beat_cnt. req_rlast=mem_rvalid & (beat_cnt==1). On that beat go to IDLE.
- Latency: request to mem_arvalid is 1 cycle; R beats pass through combinationally (0 cycles).
- Only one outstanding burst. A new grant cannot occur in the same cycle as the last beat; it happens in the following IDLE cycle.
- Simultaneous requests: the round-robin winner is taken; losers keep req_arvalid asserted and get no req_arready.
- Requesters that drop req_arvalid before grant are simply not considered.
- mem_rvalid in IDLE/ADDR is a protocol error. It is ignored and no req_rvalid is generated.
- Reset mid-burst: the burst is abandoned and the state returns to IDLE. Downstream drain is the memory side's responsibility.
- rr_ptr wrap: NUM_REQ-1 then 0. Non-power-of-two NUM_REQ wraps explicitly.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not instantiated.
- Undefined: round-robin as above.

Decomposition:
- mem_arb_pkg holds:
  - the state enum typedef (IDLE, ADDR, DATA);
  - the localparam MAX_REQ=8;
  - the function for max(len,1).
- One sub-module, rr_arbiter, contains the request vector, pointer, one-hot grant and winner index. It is combinational apart from the pointer update.

Test Plan:
- Single request: req_arvalid=2'b10, addr 0x1000, len 4 -> req_arready[1] pulse; mem_arvalid next cycle with 0x1000/len 4; 4 beats routed to req_rvalid[1], rlast on beat 4; busy drops after.
- Simultaneous: both valid from reset -> req 0 granted first, then req 1; repeat -> req 0 again (rr_ptr alternates). With MEM_ARB_FIXED_PRIO_EN and req 0 re-requesting -> req 0 always wins.
- Backpressure: mem_arready low 5 cycles -> mem_arvalid and all fields stable throughout; no req_rvalid until the handshake.
- len=0 request -> exactly 1 beat, rlast on it, return to IDLE.
- Stray mem_rvalid in IDLE -> no req_rvalid, state unchanged.
- rst_n asserted mid-DATA after 2 of 4 beats -> outputs zero immediately (async); after release, state is IDLE and a new request is granted normally.
